// File: rtl/segre_pkg.sv
// Shared types and sizing for the data-side MMU responder: FSM states,
// cache geometry constants and the lane-alignment helper.
package segre_pkg;

   localparam int ADDR_SIZE         = 32;
   localparam int DCACHE_LANE_SIZE  = 128;
   localparam int DCACHE_INDEX_SIZE = 2;
   localparam int NUM_LANES         = 2 ** DCACHE_INDEX_SIZE;
   localparam int LANE_OFFSET_W     = $clog2(DCACHE_LANE_SIZE / 8);

   typedef enum logic [1:0] {
      IDLE,
      RD_REQ,
      RESP,
      WB_REQ
   } dmmu_state_e;

   // Clears the byte offset within a lane so every memory access is lane aligned
   function automatic logic [ADDR_SIZE-1:0] laneAlign(input logic [ADDR_SIZE-1:0] a);
      return a & ~ADDR_SIZE'((1 << LANE_OFFSET_W) - 1);
   endfunction

endpackage

// File: rtl/segre_dmmu_lru.sv
// True-LRU tracker for the data-cache lanes: one age counter per lane, the
// ages always form a permutation and the oldest lane is the replacement victim.
module segre_dmmu_lru
   import segre_pkg::*;
(
   input  logic                         clk_i,
   input  logic                         rsn_i,
   input  logic                         access_i,
   input  logic [DCACHE_INDEX_SIZE-1:0] access_index_i,
   input  logic                         fill_i,
   output logic [DCACHE_INDEX_SIZE-1:0] victim_o
);

   logic [DCACHE_INDEX_SIZE-1:0] r_age     [NUM_LANES];
   logic [DCACHE_INDEX_SIZE-1:0] w_ageAcc  [NUM_LANES];
   logic [DCACHE_INDEX_SIZE-1:0] w_ageNext [NUM_LANES];
   logic [DCACHE_INDEX_SIZE-1:0] w_victim;
   logic [DCACHE_INDEX_SIZE-1:0] w_accRef;
   logic [DCACHE_INDEX_SIZE-1:0] w_fillRef;

   always_comb begin
      w_victim = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (r_age[i] == DCACHE_INDEX_SIZE'(NUM_LANES - 1)) begin
            w_victim = DCACHE_INDEX_SIZE'(i);
         end
      end
   end

   // Hit touch is applied first, the fill touch of the victim lane last
   always_comb begin
      w_accRef = r_age[access_index_i];
      for (int i = 0; i < NUM_LANES; i++) begin
         w_ageAcc[i] = r_age[i];
         if (access_i) begin
            if (DCACHE_INDEX_SIZE'(i) == access_index_i) begin
               w_ageAcc[i] = '0;
            end else if (r_age[i] < w_accRef) begin
               w_ageAcc[i] = r_age[i] + 1'b1;
            end
         end
      end
      w_fillRef = w_ageAcc[w_victim];
      for (int i = 0; i < NUM_LANES; i++) begin
         w_ageNext[i] = w_ageAcc[i];
         if (fill_i) begin
            if (DCACHE_INDEX_SIZE'(i) == w_victim) begin
               w_ageNext[i] = '0;
            end else if (w_ageAcc[i] < w_fillRef) begin
               w_ageNext[i] = w_ageAcc[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rsn_i) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            r_age[i] <= DCACHE_INDEX_SIZE'(i);
         end
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            r_age[i] <= w_ageNext[i];
         end
      end
   end

   assign victim_o = w_victim;

endmodule

// File: rtl/segre_dmmu_responder.sv
// Memory-facing end of the data-cache miss/writeback protocol.
// Define SEGRE_DMMU_WB_BUFFER_EN for the one-entry writeback buffer variant.
module segre_dmmu_responder
   import segre_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                         clk_i,
   input  logic                         rsn_i,
   input  logic                         miss_i,
   input  logic [ADDR_SIZE-1:0]         addr_i,
   input  logic                         cache_access_i,
   input  logic [DCACHE_INDEX_SIZE-1:0] access_index_i,
   input  logic                         writeback_i,
   input  logic [ADDR_SIZE-1:0]         wb_addr_i,
   input  logic [DCACHE_LANE_SIZE-1:0]  wb_data_i,
   output logic                         data_rdy_o,
   output logic [ADDR_SIZE-1:0]         addr_o,
   output logic [DCACHE_LANE_SIZE-1:0]  data_o,
   output logic [DCACHE_INDEX_SIZE-1:0] lru_index_o,
   output logic                         mem_req_o,
   output logic                         mem_we_o,
   output logic [ADDR_SIZE-1:0]         mem_addr_o,
   output logic [DCACHE_LANE_SIZE-1:0]  mem_wdata_o,
   input  logic                         mem_ack_i,
   input  logic [DCACHE_LANE_SIZE-1:0]  mem_rdata_i,
   output logic                         busy_o,
   output logic                         err_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   dmmu_state_e                 r_state;
   logic                        r_dataRdy;
   logic [ADDR_SIZE-1:0]        r_missAddr;
   logic [DCACHE_LANE_SIZE-1:0] r_data;
   logic                        r_memReq;
   logic                        r_memWe;
   logic [ADDR_SIZE-1:0]        r_memAddr;
   logic [DCACHE_LANE_SIZE-1:0] r_memWdata;
   logic [CNT_W-1:0]            r_waitCnt;
   logic                        r_err;
   logic                        r_wbPend;
   logic [ADDR_SIZE-1:0]        r_wbAddr;
   logic [DCACHE_LANE_SIZE-1:0] r_wbData;

   logic [ADDR_SIZE-1:0]        w_missAddr;
   logic [ADDR_SIZE-1:0]        w_wbAddr;
   logic                        w_waiting;

   assign w_missAddr = laneAlign(addr_i);
   assign w_wbAddr   = laneAlign(wb_addr_i);
   assign w_waiting  = (r_state == RD_REQ || r_state == WB_REQ) && !mem_ack_i;

   segre_dmmu_lru u_lru (
      .clk_i          (clk_i),
      .rsn_i          (rsn_i),
      .access_i       (cache_access_i),
      .access_index_i (access_index_i),
      .fill_i         (r_dataRdy),
      .victim_o       (lru_index_o)
   );

   always_ff @(posedge clk_i) begin
      if (rsn_i) begin
         r_state    <= IDLE;
         r_dataRdy  <= 1'b0;
         r_missAddr <= '0;
         r_data     <= '0;
         r_memReq   <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_waitCnt  <= '0;
         r_err      <= 1'b0;
         r_wbPend   <= 1'b0;
         r_wbAddr   <= '0;
         r_wbData   <= '0;
      end else begin
         r_dataRdy <= 1'b0;

         // Saturating wait counter; the error is sticky but the request stays up
         if (w_waiting) begin
            if (r_waitCnt != CNT_W'(TIMEOUT_CYCLES)) begin
               r_waitCnt <= r_waitCnt + CNT_W'(1);
            end
            if (r_waitCnt >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
               r_err <= 1'b1;
            end
         end else begin
            r_waitCnt <= '0;
         end

         case (r_state)
            IDLE: begin
`ifdef SEGRE_DMMU_WB_BUFFER_EN
               if (miss_i) begin
                  r_missAddr <= w_missAddr;
                  if (r_wbPend && r_wbAddr == w_missAddr) begin
                     r_data    <= r_wbData;
                     r_dataRdy <= 1'b1;
                     r_state   <= RESP;
                  end else begin
                     r_memReq  <= 1'b1;
                     r_memWe   <= 1'b0;
                     r_memAddr <= w_missAddr;
                     r_state   <= RD_REQ;
                  end
               end else if (r_wbPend) begin
                  r_memReq   <= 1'b1;
                  r_memWe    <= 1'b1;
                  r_memAddr  <= r_wbAddr;
                  r_memWdata <= r_wbData;
                  r_state    <= WB_REQ;
               end
`else
               if (r_wbPend || writeback_i) begin
                  r_memReq   <= 1'b1;
                  r_memWe    <= 1'b1;
                  r_memAddr  <= r_wbPend ? r_wbAddr : w_wbAddr;
                  r_memWdata <= r_wbPend ? r_wbData : wb_data_i;
                  r_state    <= WB_REQ;
               end else if (miss_i) begin
                  r_missAddr <= w_missAddr;
                  r_memReq   <= 1'b1;
                  r_memWe    <= 1'b0;
                  r_memAddr  <= w_missAddr;
                  r_state    <= RD_REQ;
               end
`endif
            end
            RD_REQ: begin
               if (mem_ack_i) begin
                  r_data    <= mem_rdata_i;
                  r_dataRdy <= 1'b1;
                  r_memReq  <= 1'b0;
                  r_state   <= RESP;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            WB_REQ: begin
               if (mem_ack_i) begin
                  r_memReq <= 1'b0;
                  r_memWe  <= 1'b0;
                  r_wbPend <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase

         // Capture comes after the case so a refill of a draining buffer wins over its clear
`ifdef SEGRE_DMMU_WB_BUFFER_EN
         if (writeback_i) begin
            if (!r_wbPend || (r_state == WB_REQ && mem_ack_i)) begin
               r_wbPend <= 1'b1;
               r_wbAddr <= w_wbAddr;
               r_wbData <= wb_data_i;
            end else begin
               r_err <= 1'b1;
            end
         end
`else
         if (writeback_i) begin
            if ((r_state == IDLE || r_state == RESP) && !r_wbPend) begin
               r_wbPend <= 1'b1;
               r_wbAddr <= w_wbAddr;
               r_wbData <= wb_data_i;
            end else begin
               r_err <= 1'b1;
            end
         end
`endif
      end
   end

   assign data_rdy_o  = r_dataRdy;
   assign addr_o      = r_missAddr;
   assign data_o      = r_data;
   assign mem_req_o   = r_memReq;
   assign mem_we_o    = r_memWe;
   assign mem_addr_o  = r_memAddr;
   assign mem_wdata_o = r_memWdata;
   assign busy_o      = (r_state != IDLE);
   assign err_o       = r_err;

endmodule
